fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the pipelined MIPS core. It owns the PC, issues instruction requests to the icache, and registers fetched words into the IF/ID latch whose `instr` output drives the control unit's `instr` input. It absorbs hazard stalls with a one-entry skid buffer, squashes on branch/jump redirect, and stops fetching once decode reports HALT.

## Interface
Parameters:
- `PC_INIT`, 32'h0000_0000, PC value loaded on reset.

Ports (word_t is 32 bits):
- `CLK` in 1: the single clock; all state updates on the rising edge.
- `nRST` in 1: asynchronous, active-low reset.
- `ihit` in 1: icache has `iload` valid for `iaddr` this cycle.
- `iload` in word_t: instruction word from the icache.
- `iREN` out 1: instruction read request.
- `iaddr` out word_t: fetch address, always equal to the current PC.
- `stall` in 1: hazard unit holds the IF/ID latch.
- `redirect` in 1: a taken branch or jump; flush and reload the PC.
- `redirect_addr` in word_t: target PC when `redirect` is high.
- `halt_id` in 1: decode of the IF/ID instruction is HALT.
- `instr` out word_t: IF/ID instruction; 0 (sll nop) when the latch holds a bubble.
- `npc` out word_t: PC+4 of `instr`.
- `ifid_valid` out 1: the IF/ID latch holds a real instruction.
- `halted` out 1: the stage is in HALTED.
- `fetch_cnt` out 32: present only with FETCH_PERF_EN.
- `stall_cnt` out 32: present only with FETCH_PERF_EN.

## Operation
- States: EMPTY (buffer empty, fetching), HELD (skid buffer full), HALTED.
- `iREN` = (state==EMPTY). `iaddr` = pc. Both are combinational from registers.
- Per-cycle priority: reset > redirect > halt_id > stall > normal.
- **redirect** (any state except HALTED):
  - pc <= redirect_addr.
  - Skid buffer is discarded and state goes to EMPTY.
  - IF/ID gets a bubble: instr=0, ifid_valid=0.
  - A concurrent `ihit` is ignored.
  - Redirect beats a simultaneous halt_id; the HALT is squashed.
- **halt_id** (and no redirect):
  - state <= HALTED; pc holds; IF/ID gets a bubble.
  - HALTED is sticky until nRST: `iREN`=0, and `redirect`, `stall` and `ihit` are all ignored.
- **stall**: IF/ID holds its value.
  - In EMPTY with ihit: buffer <= {iload, pc+4}, pc <= pc+4, state goes to HELD.
  - In HELD: nothing changes.
- **normal** (no stall):
  - In HELD: IF/ID <= buffer (valid), state goes to EMPTY, and no fetch is issued this cycle.
  - In EMPTY with ihit: IF/ID <= {iload, pc+4, valid}, pc <= pc+4.
  - In EMPTY without ihit: IF/ID gets a bubble and pc holds.
- PC arithmetic is 32-bit unsigned and wraps 32'hFFFF_FFFC -> 0. The low two bits are carried unchanged (no alignment check).

## Timing
- Reset values: pc=PC_INIT, state=EMPTY, instr=0, npc=0, ifid_valid=0, halted=0, buffer cleared, counters=0. So `iREN`=1 and `iaddr`=PC_INIT immediately after reset.
- Fetch latency: an `ihit` in cycle N (unstalled) makes `instr` visible in cycle N+1.
- Stall release from HELD: the buffered instruction appears the cycle after `stall` falls. The next request issues in that same cycle.
- Redirect: `iaddr`=redirect_addr in cycle N+1; the earliest target instruction is in IF/ID at N+2.
- Asserting nRST mid-stall, mid-HELD or while HALTED returns everything to reset values asynchronously.

## Configuration
- `FETCH_PERF_EN` defined:
  - `fetch_cnt` increments on every accepted ihit (EMPTY, no redirect, no halt).
  - `stall_cnt` increments every cycle that `stall` && `ifid_valid`.
  - Both are 32-bit, wrap, cleared by reset, and frozen in HALTED.
- `FETCH_PERF_EN` undefined: both ports and their registers are absent; all other behaviour is identical.

## Structure
- In `cpu_types_pkg`: `fetch_state_t` enum {EMPTY, HELD, HALTED}, and an `ifid_t` struct {instr, npc, valid}. Reuse `word_t`.
- One sub-module, `fetch_skid_buf`: a one-entry {instr, npc} holding register with load/clear/full. The FSM, PC and IF/ID latch stay in `fetch_stage`.

## Test plan
- **Reset then ihit.** Release nRST with ihit=1, iload=32'h2001_0005. Required: iaddr=0, then next cycle instr=32'h2001_0005, npc=4, ifid_valid=1, iaddr=4.
- **Stall with a skid capture.** stall=1 for 3 cycles with ihit=1 on the first. Required: instr unchanged, state HELD, iREN=0, pc=+4. After stall=0: buffered word appears next cycle, iREN=1.
- **Redirect during HELD.** Apply redirect=1, redirect_addr=32'h0000_0100. Required: buffer dropped, ifid_valid=0 next cycle, iaddr=32'h100.
- **Halt.** halt_id=1 in cycle N. Required: halted=1, iREN=0 from N+1. Later redirect, stall and ihit cause no change. nRST restores iaddr=PC_INIT.
- **Redirect and halt together.** Assert both in the same cycle. Required: halted stays 0, pc=redirect_addr.
- **PC wrap (FETCH_PERF_EN).** PC_INIT=32'hFFFF_FFFC, one ihit. Required: npc=0, iaddr=0, fetch_cnt=1. Then 5 cycles of stall with a valid instruction: stall_cnt=5.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types for the fetch stage and its helpers
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        HELD   = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    typedef struct packed {
        word_t instr;
        word_t npc;
        logic  valid;
    } ifid_t;

    // An all-zero word decodes as sll $0,$0,0, so it doubles as the bubble.
    localparam word_t NOP_INSTR = 32'h0000_0000;
    localparam word_t PC_STEP   = 32'd4;

    localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, npc: 32'h0, valid: 1'b0};

endpackage

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - one-entry {instr, npc} holding register for stalled fetches
module fetch_skid_buf
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  load,
    input  logic  clear,
    input  word_t load_instr,
    input  word_t load_npc,
    output word_t instr,
    output word_t npc,
    output logic  full
);

    // Clear wins over load so a redirect always leaves the buffer empty.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            instr <= NOP_INSTR;
            npc   <= 32'h0;
            full  <= 1'b0;
        end else if (clear) begin
            instr <= NOP_INSTR;
            npc   <= 32'h0;
            full  <= 1'b0;
        end else if (load) begin
            instr <= load_instr;
            npc   <= load_npc;
            full  <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage: PC, icache request, skid buffer, IF/ID latch (optional FETCH_PERF_EN counters)
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
)
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  word_t       iload,
    output logic        iREN,
    output word_t       iaddr,
    input  logic        stall,
    input  logic        redirect,
    input  word_t       redirect_addr,
    input  logic        halt_id,
    output word_t       instr,
    output word_t       npc,
    output logic        ifid_valid,
    output logic        halted
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
`endif
);

    fetch_state_t state, state_next;
    word_t        pc, pc_plus4;
    ifid_t        ifid;

    logic  active, do_redirect, do_halt, do_stall, do_normal, accept;
    logic  buf_load, buf_clear, buf_full;
    word_t buf_instr, buf_npc;

    assign pc_plus4 = pc + PC_STEP;

    // Decode the per-cycle priority: redirect > halt_id > stall > normal; HALTED ignores all.
    always_comb begin
        active      = (state != HALTED);
        do_redirect = active && redirect;
        do_halt     = active && !redirect && halt_id;
        do_stall    = active && !redirect && !halt_id && stall;
        do_normal   = active && !redirect && !halt_id && !stall;
        accept      = (state == EMPTY) && ihit && !redirect && !halt_id;
        buf_load    = do_stall && accept;
        buf_clear   = do_redirect || do_halt || (do_normal && state == HELD);
    end

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= EMPTY;
        else       state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        if (do_redirect)                       state_next = EMPTY;
        else if (do_halt)                      state_next = HALTED;
        else if (buf_load)                     state_next = HELD;
        else if (do_normal && state == HELD)   state_next = EMPTY;
    end

    // FSM outputs: fetch only while the buffer is empty.
    always_comb begin
        iREN   = (state == EMPTY);
        halted = (state == HALTED);
    end

    // PC advances on every accepted hit, stalled or not, and reloads on redirect.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)            pc <= PC_INIT;
        else if (do_redirect) pc <= redirect_addr;
        else if (accept)      pc <= pc_plus4;
    end

    // IF/ID latch: bubble on squash, hold on stall, drain buffer before new fetches.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ifid <= IFID_BUBBLE;
        end else if (do_redirect || do_halt) begin
            ifid <= IFID_BUBBLE;
        end else if (do_normal) begin
            if (state == HELD)
                ifid <= '{instr: buf_instr, npc: buf_npc, valid: buf_full};
            else if (ihit)
                ifid <= '{instr: iload, npc: pc_plus4, valid: 1'b1};
            else
                ifid <= IFID_BUBBLE;
        end
    end

    fetch_skid_buf u_skid (
        .CLK        (CLK),
        .nRST       (nRST),
        .load       (buf_load),
        .clear      (buf_clear),
        .load_instr (iload),
        .load_npc   (pc_plus4),
        .instr      (buf_instr),
        .npc        (buf_npc),
        .full       (buf_full)
    );

    assign iaddr      = pc;
    assign instr      = ifid.instr;
    assign npc        = ifid.npc;
    assign ifid_valid = ifid.valid;

`ifdef FETCH_PERF_EN
    // Performance counters; both freeze once HALTED.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fetch_cnt <= 32'h0;
            stall_cnt <= 32'h0;
        end else begin
            if (accept)
                fetch_cnt <= fetch_cnt + 32'd1;
            if (active && stall && ifid.valid)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule
